// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg
//   Shared constants and helpers for the sync_debounce block.
//   MIN_DEPTH        : smallest synchronizer depth the block will build
//   MIN_STABLE_COUNT : smallest debounce hold count the block will build
//   GLITCH_CNT_W     : width of the optional aborted-transition counter
//   clogb2()         : ceil(log2(value)), used to size the debounce counters
package sync_debounce_pkg;

  localparam int MIN_DEPTH        = 2;
  localparam int MIN_STABLE_COUNT = 1;
  localparam int GLITCH_CNT_W     = 16;

  // Smallest r with 2**r >= value. The result is never below 1, so a counter
  // sized by it always has at least one bit.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   Debounce filter for one synchronized bit. dout follows s only after s has
//   differed from dout for STABLE_COUNT consecutive cycles. The caller passes
//   an already clamped STABLE_COUNT (>= 1).
//   clk, resetn : clock, synchronous active-low reset
//   s           : synchronized input bit
//   dout        : debounced level
//   rise, fall  : registered one-cycle pulses, aligned with the new dout value
//   stable      : s matches dout and no count is in progress
//   abort       : a pending transition is being dropped this cycle
module debounce_channel
  import sync_debounce_pkg::*;
#(
  parameter int   STABLE_COUNT = 4,
  parameter logic RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic s,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic stable,
  output logic abort
);

  localparam int            CW   = clogb2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt  <= '0;
      dout <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == dout) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // s has now differed for STABLE_COUNT cycles: commit and flag the edge
        dout <= s;
        cnt  <= '0;
        rise <= s;
        fall <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable = (s == dout) && (cnt == '0);
  assign abort  = (s == dout) && (cnt != '0);

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce
//   Multi-channel synchronizer with per-channel debounce and edge events.
//   Parameters: WIDTH channels, DEPTH sync stages (min 2), STABLE_COUNT hold
//   cycles (min 1), RESET_VAL reset value of the sync chain and dout.
//   clk, resetn  : clock, synchronous active-low reset
//   din          : asynchronous inputs
//   dout         : debounced, synchronized levels
//   rise, fall   : one-cycle pulses on dout 0->1 / 1->0
//   stable       : per channel, synchronized value equals dout, no count running
//   busy         : any channel not stable
//   glitch_clr   : synchronous clear of glitch_count
//   glitch_count : saturating count of cycles with at least one aborted
//                  transition
//   glitch_clr and glitch_count exist only when SYNC_DEBOUNCE_GLITCH_CNT_EN is
//   defined.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH        = 1,
  parameter int               DEPTH        = 2,
  parameter int               STABLE_COUNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL    = {WIDTH{1'b0}}
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [WIDTH-1:0]        din,
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_count,
`endif
  output logic [WIDTH-1:0]        dout,
  output logic [WIDTH-1:0]        rise,
  output logic [WIDTH-1:0]        fall,
  output logic [WIDTH-1:0]        stable,
  output logic                    busy
);

  localparam int SYNC_DEPTH = (DEPTH < MIN_DEPTH) ? MIN_DEPTH : DEPTH;
  localparam int STABLE_EFF = (STABLE_COUNT < MIN_STABLE_COUNT) ?
                              MIN_STABLE_COUNT : STABLE_COUNT;

  // Plain flop chain; nothing may sit between stages or the metastability
  // resolution time of the chain is eaten into.
  logic [WIDTH-1:0] sync_q [SYNC_DEPTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] abort;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= RESET_VAL;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_DEPTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_COUNT (STABLE_EFF),
      .RESET_VAL    (RESET_VAL[i])
    ) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .s      (s[i]),
      .dout   (dout[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .stable (stable[i]),
      .abort  (abort[i])
    );
  end

  assign busy = ~&stable;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] glitch_q;

  // One increment per cycle no matter how many channels abort together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      glitch_q <= '0;
    end else if (glitch_clr) begin
      glitch_q <= '0;
    end else if ((|abort) && (glitch_q != '1)) begin
      glitch_q <= glitch_q + 1'b1;
    end
  end

  assign glitch_count = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = ^abort;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
`timescale 1ns/1ps
module tb_sync_debounce;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] din    = 4'hF;
  logic [3:0] dout, rise, fall, stable;
  logic       busy;
  logic       glitch_clr = 1'b0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_count;
  logic [15:0] glitch_count2;
`endif

  logic din2 = 1'b0;
  logic dout2, rise2, fall2, stable2, busy2;

  int edge_n  = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         e;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] d;
  } ev_t;
  ev_t exp_q[$];

  sync_debounce #(.WIDTH(4), .DEPTH(2), .STABLE_COUNT(4), .RESET_VAL(4'h0)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .din          (din),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr   (glitch_clr),
    .glitch_count (glitch_count),
`endif
    .dout         (dout),
    .rise         (rise),
    .fall         (fall),
    .stable       (stable),
    .busy         (busy)
  );

  // Clamped instance: DEPTH=1, STABLE_COUNT=0 must act as DEPTH=2, STABLE_COUNT=1.
  sync_debounce #(.WIDTH(1), .DEPTH(1), .STABLE_COUNT(0), .RESET_VAL(1'b0)) dut2 (
    .clk          (clk),
    .resetn       (resetn),
    .din          (din2),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr   (1'b0),
    .glitch_count (glitch_count2),
`endif
    .dout         (dout2),
    .rise         (rise2),
    .fall         (fall2),
    .stable       (stable2),
    .busy         (busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic push_ev(input int e, input logic [3:0] r, input logic [3:0] f,
                         input logic [3:0] d);
    ev_t ev;
    ev.e = e; ev.r = r; ev.f = f; ev.d = d;
    exp_q.push_back(ev);
  endtask

  // Park on the negedge that follows posedge number e.
  task automatic to_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_dout"},   32'(dout),   32'h0);
    check({tag, "_rise"},   32'(rise),   32'h0);
    check({tag, "_fall"},   32'(fall),   32'h0);
    check({tag, "_stable"}, 32'(stable), 32'hF);
    check({tag, "_busy"},   32'(busy),   32'h0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check({tag, "_glitch"}, 32'(glitch_count), 32'h0);
`endif
  endtask

  // Monitor: any edge pulse must match the next queued expectation.
  always @(negedge clk) begin
    if ((rise | fall) != 4'b0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event at edge %0d: rise=%b fall=%b dout=%b, expected none",
                 edge_n, rise, fall, dout);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("event_edge", 32'(edge_n), 32'(ev.e));
        check("event_rise", 32'(rise),   32'(ev.r));
        check("event_fall", 32'(fall),   32'(ev.f));
        check("event_dout", 32'(dout),   32'(ev.d));
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish at edge %0d", edge_n);
    $fatal(1);
  end

  initial begin
    // Reset held for three edges with all inputs high.
    for (int e = 1; e <= 3; e++) begin
      to_edge(e);
      check_idle("reset");
    end
    resetn = 1'b1;
    din    = 4'h0;
    to_edge(4);
    check_idle("post_reset");

    // Edge latency on ch0: din set before edge 10, dout at edge 15.
    to_edge(9);
    din = 4'b0001;
    push_ev(15, 4'b0001, 4'b0000, 4'b0001);
    for (int e = 10; e <= 15; e++) begin
      to_edge(e);
      check("latency_busy", 32'(busy), (e >= 11 && e <= 14) ? 32'h1 : 32'h0);
      if (e == 14) check("latency_dout_before", 32'(dout), 32'h0);
      if (e == 12) check("latency_stable", 32'(stable), 32'hE);
    end

    // Glitch on ch2: three cycles high, then back low.
    to_edge(20);
    din = 4'b0101;
    to_edge(23);
    din = 4'b0001;
    to_edge(24);
    check("glitch_busy", 32'(busy), 32'h1);
    to_edge(26);
    check("glitch_dout",   32'(dout),   32'h1);
    check("glitch_stable", 32'(stable), 32'hF);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("glitch_count_one", 32'(glitch_count), 32'h1);
`endif

    // Simultaneous rise/fall on two channels, in both directions.
    to_edge(30);
    din = 4'b0010;
    push_ev(36, 4'b0010, 4'b0001, 4'b0010);
    to_edge(40);
    din = 4'b0001;
    push_ev(46, 4'b0001, 4'b0010, 4'b0001);
    to_edge(45);
    check("simul_dout_mid", 32'(dout), 32'h2);

    // Reset mid-count on ch3 (cnt=2 when reset is sampled).
    to_edge(50);
    din = 4'b1001;
    to_edge(54);
    resetn = 1'b0;
    to_edge(55);
    check("midreset_dout", 32'(dout), 32'h0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("midreset_glitch", 32'(glitch_count), 32'h0);
`endif
    to_edge(56);
    resetn = 1'b1;
    push_ev(62, 4'b1001, 4'b0000, 4'b1001);
    to_edge(61);
    check("midreset_dout_61", 32'(dout), 32'h0);
    check("midreset_busy_61", 32'(busy), 32'h1);

    // Abort on ch2 at edge 75 coinciding with glitch_clr.
    to_edge(70);
    din = 4'b1101;
    to_edge(72);
    din = 4'b1001;
    to_edge(74);
    glitch_clr = 1'b1;
    to_edge(75);
    glitch_clr = 1'b0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("clr_wins", 32'(glitch_count), 32'h0);
`endif

    // Two channels abort in the same cycle (edge 81): one increment.
    to_edge(76);
    din = 4'b1111;
    to_edge(78);
    din = 4'b1001;
    to_edge(82);
    check("dual_dout", 32'(dout), 32'h9);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("dual_glitch", 32'(glitch_count), 32'h1);
    to_edge(84);
    force dut.glitch_q = 16'hFFF0;
    to_edge(85);
    release dut.glitch_q;
`endif

    // 200-cycle chatter on ch1: about 100 aborts, must saturate.
    for (int i = 0; i < 200; i++) begin
      to_edge(85 + i);
      din = (i % 2 == 0) ? 4'b1011 : 4'b1001;
    end
    to_edge(285);
    din = 4'b1001;
    to_edge(295);
    check("chatter_dout", 32'(dout), 32'h9);
    check("chatter_busy", 32'(busy), 32'h0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("glitch_saturate", 32'(glitch_count), 32'hFFFF);
`endif

    // Clamped instance: din2 set before edge 301, dout2 at edge 303.
    to_edge(300);
    din2 = 1'b1;
    to_edge(302);
    check("clamp_dout_302", 32'(dout2), 32'h0);
    to_edge(303);
    check("clamp_dout_303", 32'(dout2), 32'h1);
    check("clamp_rise_303", 32'(rise2), 32'h1);
    to_edge(304);
    check("clamp_rise_304", 32'(rise2), 32'h0);

    to_edge(310);
    check("events_drained", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
